// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths, the zero-register index and the write-request record
package cpu_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [AW-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic en;
    logic [AW-1:0] num;
    logic [DW-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-MDU-write busy bits plus sticky protocol-error detection
// ports: clock/resetn; set_en/set_num (decode issue); clr_en/clr_num (buffer drain);
//        wb_en/wb_num (WB request); md_en/md_num (MDU accept); busy, proto_err outputs
module wb_scoreboard import cpu_pkg::*; #(
  parameter int AW = cpu_pkg::AW
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               set_en,
  input  logic [AW-1:0]      set_num,
  input  logic               clr_en,
  input  logic [AW-1:0]      clr_num,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_num,
  input  logic               md_en,
  input  logic [AW-1:0]      md_num,
  output logic [2**AW-1:0]   busy,
  output logic               proto_err
);
  localparam int NR = 2**AW;
  logic [NR-1:0] set_m, clr_m;
  logic err;
  // register 0 is never tracked, so busy[0] stays 0 and MDU results to r0 are not flagged
  assign set_m = {{(NR-1){1'b0}}, set_en && set_num != REG_ZERO} << set_num;
  assign clr_m = {{(NR-1){1'b0}}, clr_en} << clr_num;
  assign err = (set_en && busy[set_num]) || (wb_en && busy[wb_num]) ||
               (md_en && md_num != REG_ZERO && !busy[md_num]);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy      <= '0;
      proto_err <= 1'b0;
    end else begin
      busy      <= (busy & ~clr_m) | set_m;
      proto_err <= proto_err | err;
    end
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: merges WB-stage and MDU writes onto the single register-file write port
// ports: clock/resetn; wb_reg_write/wb_num/wb_data in, wb_stall out; md_valid/md_num/md_data in,
//        md_ready out; md_issue/md_issue_num in; busy scoreboard; reg_write/num_write/data_write
//        to the register file; proto_err sticky flag.
// GPR_WB_FWD_EN adds rs/rt/a_in/b_in inputs and a_out/b_out bypassed read data.
// DW/AW must match cpu_pkg since requests are carried in wr_req_t.
module gpr_wb_arbiter import cpu_pkg::*; #(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wb_reg_write,
  input  logic [AW-1:0]    wb_num,
  input  logic [DW-1:0]    wb_data,
  output logic             wb_stall,
  input  logic             md_valid,
  input  logic [AW-1:0]    md_num,
  input  logic [DW-1:0]    md_data,
  output logic             md_ready,
  input  logic             md_issue,
  input  logic [AW-1:0]    md_issue_num,
  output logic [2**AW-1:0] busy,
  output logic             reg_write,
  output logic [AW-1:0]    num_write,
  output logic [DW-1:0]    data_write,
`ifdef GPR_WB_FWD_EN
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
`endif
  output logic             proto_err
);
  wr_req_t wb_req, md_req, bf, out_q, out_d;
  logic [3:0] cnt;
  logic wb_go, drain, md_acc;
  assign wb_req = '{en: wb_reg_write, num: wb_num, data: wb_data};
  assign md_req = '{en: md_valid, num: md_num, data: md_data};
  // bf.en doubles as the skid-buffer valid bit
  assign md_ready = !bf.en;
  assign md_acc   = md_req.en && md_ready;
  assign wb_stall = bf.en && cnt == 4'(STARVE_MAX);
  assign wb_go    = wb_req.en && !wb_stall;
  assign drain    = !wb_go && bf.en;
  always_comb begin
    out_d    = wb_go ? wb_req : drain ? bf : '{en: 1'b0, num: out_q.num, data: out_q.data};
    out_d.en = out_d.en && out_d.num != REG_ZERO;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
      bf    <= '0;
      cnt   <= '0;
    end else begin
      out_q <= out_d;
      bf    <= md_acc ? md_req : drain ? '0 : bf;
      cnt   <= drain ? 4'd0 : (wb_go && bf.en) ? cnt + 4'd1 : cnt;
    end
  end
  assign reg_write  = out_q.en;
  assign num_write  = out_q.num;
  assign data_write = out_q.data;
`ifdef GPR_WB_FWD_EN
  // bypass the not-yet-committed port write into decode reads
  assign a_out = (out_q.en && out_q.num == rs && rs != REG_ZERO) ? out_q.data : a_in;
  assign b_out = (out_q.en && out_q.num == rt && rt != REG_ZERO) ? out_q.data : b_in;
`endif
  wb_scoreboard #(.AW(AW)) u_sb (
    .clock(clock), .resetn(resetn),
    .set_en(md_issue), .set_num(md_issue_num),
    .clr_en(drain), .clr_num(bf.num),
    .wb_en(wb_reg_write), .wb_num(wb_num),
    .md_en(md_acc), .md_num(md_num),
    .busy(busy), .proto_err(proto_err)
  );
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;
  logic clock = 0, resetn = 0;
  logic wb_reg_write = 0, md_valid = 0, md_issue = 0;
  logic [4:0] wb_num = 0, md_num = 0, md_issue_num = 0;
  logic [31:0] wb_data = 0, md_data = 0;
  logic wb_stall, md_ready, reg_write, proto_err;
  logic [4:0] num_write;
  logic [31:0] data_write, busy;
`ifdef GPR_WB_FWD_EN
  logic [4:0] rs = 0, rt = 0;
  logic [31:0] a_in = 0, b_in = 0, a_out, b_out;
`endif
  int total = 0, bad = 0;

  gpr_wb_arbiter #(.DW(32), .AW(5), .STARVE_MAX(4)) dut (
    .clock(clock), .resetn(resetn),
    .wb_reg_write(wb_reg_write), .wb_num(wb_num), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_valid(md_valid), .md_num(md_num), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_num(md_issue_num), .busy(busy),
    .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
`ifdef GPR_WB_FWD_EN
    .rs(rs), .rt(rt), .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out),
`endif
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL rst_reg_write got %b exp 0", reg_write); end
    total++; if (num_write !== 5'd0) begin bad++; $display("FAIL rst_num_write got %0d exp 0", num_write); end
    total++; if (data_write !== 32'd0) begin bad++; $display("FAIL rst_data_write got %h exp 0", data_write); end
    total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL rst_md_ready got %b exp 1", md_ready); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL rst_busy got %h exp 0", busy); end
    total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL rst_wb_stall got %b exp 0", wb_stall); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got %b exp 0", proto_err); end
    tick;
    resetn = 1;
    tick;
  endtask

  task automatic test_wb_write;
    wb_reg_write = 1; wb_num = 5; wb_data = 32'h1234_5678;
    tick;
    wb_reg_write = 0;
    total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL wb_reg_write got %b exp 1", reg_write); end
    total++; if (num_write !== 5'd5) begin bad++; $display("FAIL wb_num got %0d exp 5", num_write); end
    total++; if (data_write !== 32'h1234_5678) begin bad++; $display("FAIL wb_data got %h exp 12345678", data_write); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL wb_busy got %h exp 0", busy); end
    tick;
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL wb_idle got %b exp 0", reg_write); end
    total++; if (num_write !== 5'd5) begin bad++; $display("FAIL wb_hold_num got %0d exp 5", num_write); end
  endtask

  task automatic test_mdu_path;
    md_issue = 1; md_issue_num = 9;
    tick;
    md_issue = 0;
    total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL md_busy_set got %h exp 00000200", busy); end
    tick; tick;
    md_valid = 1; md_num = 9; md_data = 32'hDEAD_BEEF;
    #1;
    total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL md_ready_pre got %b exp 1", md_ready); end
    tick;
    md_valid = 0;
    total++; if (md_ready !== 1'b0) begin bad++; $display("FAIL md_ready_full got %b exp 0", md_ready); end
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL md_no_same_cycle got %b exp 0", reg_write); end
    total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL md_busy_held got %h exp 00000200", busy); end
    tick;
    total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL md_write got %b exp 1", reg_write); end
    total++; if (num_write !== 5'd9) begin bad++; $display("FAIL md_num got %0d exp 9", num_write); end
    total++; if (data_write !== 32'hDEAD_BEEF) begin bad++; $display("FAIL md_data got %h exp deadbeef", data_write); end
    total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL md_ready_drained got %b exp 1", md_ready); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL md_busy_clr got %h exp 0", busy); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL md_proto got %b exp 0", proto_err); end
  endtask

  task automatic test_starve;
    md_issue = 1; md_issue_num = 12;
    tick;
    md_issue = 0;
    wb_reg_write = 1; wb_num = 1; wb_data = 32'h100;
    md_valid = 1; md_num = 12; md_data = 32'h0000_CAFE;
    tick;
    md_valid = 0;
    total++; if (num_write !== 5'd1 || reg_write !== 1'b1) begin bad++; $display("FAIL st_first got we=%b num=%0d exp we=1 num=1", reg_write, num_write); end
    total++; if (md_ready !== 1'b0) begin bad++; $display("FAIL st_buffered got %b exp 0", md_ready); end
    for (int i = 1; i <= 4; i++) begin
      wb_num = 5'(1 + i); wb_data = 32'h100 + 32'(i);
      tick;
      total++; if (reg_write !== 1'b1 || num_write !== 5'(1 + i)) begin bad++; $display("FAIL st_wb%0d got we=%b num=%0d exp we=1 num=%0d", i, reg_write, num_write, 1 + i); end
      total++; if (wb_stall !== (i == 4)) begin bad++; $display("FAIL st_stall%0d got %b exp %b", i, wb_stall, i == 4); end
    end
    wb_num = 6; wb_data = 32'h106;
    tick;
    total++; if (reg_write !== 1'b1 || num_write !== 5'd12 || data_write !== 32'h0000_CAFE) begin bad++; $display("FAIL st_drain got we=%b num=%0d data=%h exp we=1 num=12 data=0000cafe", reg_write, num_write, data_write); end
    total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL st_stall_drop got %b exp 0", wb_stall); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL st_busy got %h exp 0", busy); end
    tick;
    wb_reg_write = 0;
    total++; if (num_write !== 5'd6 || data_write !== 32'h106) begin bad++; $display("FAIL st_resume got num=%0d data=%h exp num=6 data=106", num_write, data_write); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL st_proto got %b exp 0", proto_err); end
  endtask

  task automatic test_r0;
    wb_reg_write = 1; wb_num = 0; wb_data = 32'h1;
    md_issue = 1; md_issue_num = 0;
    tick;
    wb_reg_write = 0; md_issue = 0;
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL r0_wb got %b exp 0", reg_write); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL r0_busy got %h exp 0", busy); end
    md_valid = 1; md_num = 0; md_data = 32'h2;
    tick;
    md_valid = 0;
    total++; if (md_ready !== 1'b0 || reg_write !== 1'b0) begin bad++; $display("FAIL r0_accept got rdy=%b we=%b exp rdy=0 we=0", md_ready, reg_write); end
    tick;
    total++; if (reg_write !== 1'b0 || md_ready !== 1'b1) begin bad++; $display("FAIL r0_drain got we=%b rdy=%b exp we=0 rdy=1", reg_write, md_ready); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL r0_proto got %b exp 0", proto_err); end
  endtask

  task automatic test_proto_reset;
    md_issue = 1; md_issue_num = 7;
    tick;
    total++; if (proto_err !== 1'b0 || busy !== 32'h80) begin bad++; $display("FAIL pe_first got err=%b busy=%h exp err=0 busy=00000080", proto_err, busy); end
    tick;
    md_issue = 0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL pe_waw got %b exp 1", proto_err); end
    md_valid = 1; md_num = 7; md_data = 32'h77;
    tick;
    md_valid = 0;
    total++; if (proto_err !== 1'b1 || md_ready !== 1'b0) begin bad++; $display("FAIL pe_sticky got err=%b rdy=%b exp err=1 rdy=0", proto_err, md_ready); end
    resetn = 0;
    #1;
    total++; if (proto_err !== 1'b0 || md_ready !== 1'b1 || busy !== 32'd0 || reg_write !== 1'b0 || num_write !== 5'd0 || data_write !== 32'd0 || wb_stall !== 1'b0) begin
      bad++; $display("FAIL pe_reset got err=%b rdy=%b busy=%h we=%b num=%0d data=%h stall=%b exp all reset", proto_err, md_ready, busy, reg_write, num_write, data_write, wb_stall);
    end
    #3 resetn = 1;
    tick;
    total++; if (reg_write !== 1'b0 || md_ready !== 1'b1) begin bad++; $display("FAIL pe_discard got we=%b rdy=%b exp we=0 rdy=1", reg_write, md_ready); end
  endtask

`ifdef GPR_WB_FWD_EN
  task automatic test_fwd;
    wb_reg_write = 1; wb_num = 3; wb_data = 32'hA5A5;
    tick;
    wb_reg_write = 0;
    rs = 3; a_in = 0; rt = 3; b_in = 1;
    #1;
    total++; if (a_out !== 32'hA5A5) begin bad++; $display("FAIL fwd_a got %h exp 0000a5a5", a_out); end
    total++; if (b_out !== 32'hA5A5) begin bad++; $display("FAIL fwd_b got %h exp 0000a5a5", b_out); end
    rs = 0; a_in = 32'h55; rt = 4; b_in = 32'h66;
    #1;
    total++; if (a_out !== 32'h55) begin bad++; $display("FAIL fwd_r0 got %h exp 00000055", a_out); end
    total++; if (b_out !== 32'h66) begin bad++; $display("FAIL fwd_miss got %h exp 00000066", b_out); end
    rs = 3;
    tick;
    total++; if (a_out !== 32'h55) begin bad++; $display("FAIL fwd_idle got %h exp 00000055", a_out); end
  endtask
`endif

  initial begin
    test_reset;
    test_wb_write;
    test_mdu_path;
    test_starve;
    test_r0;
`ifdef GPR_WB_FWD_EN
    test_fwd;
`endif
    test_proto_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Drives the single register-file write port (reg_write, num_write, data_write) of the pipelined CPU.
- Merges two writers:
  - the in-order pipeline WB stage, which has priority;
  - the multi-cycle multiply/divide unit (MDU), which returns results late.
- Keeps a pending-write scoreboard so decode can stall on registers still owed an MDU result.
- Sits between WB/MDU and the register file; its outputs feed the file's write port directly.

Parameters:
- DW, 32, data width.
- AW, 5, register index width (32 registers).
- STARVE_MAX, 4, consecutive cycles an MDU result may wait behind WB writes before WB is stalled; range 1..15.

Ports:
- clock  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- wb_reg_write  in  1  pipeline WB requests a write this cycle.
- wb_num  in  AW  WB destination register.
- wb_data  in  DW  WB write data.
- wb_stall  out  1  WB must hold its request this cycle (starvation relief).
- md_valid  in  1  MDU offers a result.
- md_num  in  AW  MDU destination register.
- md_data  in  DW  MDU result.
- md_ready  out  1  skid buffer empty; MDU result accepted when md_valid && md_ready.
- md_issue  in  1  decode issued an MDU op this cycle.
- md_issue_num  in  AW  destination of that op.
- busy  out  2**AW  scoreboard; bit n set means an MDU write to register n is pending.
- reg_write  out  1  register file write enable.
- num_write  out  AW  register file write index.
- data_write  out  DW  register file write data.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, resetn=0) clears everything: reg_write=0, num_write=0, data_write=0, buffer empty (md_ready=1), busy=0, starve counter=0, wb_stall=0, proto_err=0.
- Write-port outputs are registered, 1-cycle latency. A request sampled at edge k appears on reg_write/num_write/data_write after edge k and is committed by the register file at edge k+1.
- Skid buffer holds one MDU entry (num, data):
  - Load when md_valid && md_ready.
  - md_ready = buffer empty; it is combinational from state only, never from md_valid.
- Per-cycle arbitration, evaluated after reset:
  - WB request present and wb_stall=0: issue the WB write. The buffer holds; the starve counter increments if the buffer is full.
  - Otherwise, if the buffer is full: issue the buffered write, empty the buffer, clear busy[num], zero the counter.
  - Otherwise: reg_write=0. num_write/data_write keep their last value.
- An MDU result never writes the port in the same cycle it is accepted. The minimum MDU path is accept at edge k, port after edge k+1.
- Starvation relief: wb_stall=1 when the counter == STARVE_MAX and the buffer is full. That cycle the buffer drains. The counter returns to 0 and wb_stall drops the next cycle.
- Register 0:
  - Any write targeting register 0 (either source) produces reg_write=0 but is otherwise processed normally: the buffer drains and the counter resets.
  - md_issue with md_issue_num=0 does not set busy[0]; busy[0] is constant 0.
- Scoreboard:
  - md_issue sets busy[md_issue_num].
  - If the same index is set by issue and cleared by drain in the same cycle, set wins.
- proto_err sets and stays set until reset when any of these occur:
  - md_issue targets a register already busy (WAW).
  - wb_reg_write targets a register that is busy.
  - The MDU delivers md_num whose busy bit is clear.
- Reset mid-operation discards the buffered result and all pending busy bits.

Optional Feature:
- Macro: GPR_WB_FWD_EN.
- When defined, adds read-bypass ports:
  - rs, rt  in  AW.
  - a_in, b_in  in  DW, raw register-file read data.
  - a_out, b_out  out  DW.
- Bypass rule: a_out = data_write when reg_write && num_write==rs && rs!=0, else a_in. b_out follows the same rule with rt/b_in. This covers the write on the port that has not yet committed.
- Combinational, zero latency.
- When undefined, these ports are absent and decode reads the file directly with one extra stall cycle.

Decomposition:
- Shared package cpu_pkg:
  - DW/AW constants.
  - REG_ZERO constant.
  - A wr_req_t typedef {logic en; logic [AW-1:0] num; logic [DW-1:0] data}, used by both sources and the output.
- One natural sub-module: wb_scoreboard, covering busy set/clear and the three proto_err checks.
- Skid buffer and arbitration stay in the top.

Test Plan:
- Reset released, WB writes r5=0x1234_5678 -> next cycle reg_write=1, num_write=5, data_write=0x12345678; busy=0.
- md_issue r9, 3 cycles later MDU delivers 0xDEADBEEF with WB idle -> md_ready drops 1 cycle, write r9 appears 2 cycles after accept, busy[9] clears on drain.
- MDU result buffered while WB writes every cycle, STARVE_MAX=4 -> four WB writes issue, then wb_stall=1 for exactly one cycle with the MDU write on the port, then WB resumes.
- WB write to r0 and MDU result to r0 -> reg_write stays 0 throughout; buffer still drains; proto_err stays 0.
- md_issue r7 twice without a result in between -> proto_err=1 and stays 1; resetn pulse mid-buffer -> all outputs back to reset values.
- With GPR_WB_FWD_EN: port writing r3=0xA5A5, rs=3, a_in=0 -> a_out=0xA5A5; rs=0 -> a_out=a_in.
